mlp_host_bridge: RTL and testbench

Byte-stream command front end that sits directly upstream of the 2x2 MLP core. It parses host opcodes arriving on a valid/ready byte interface and drives the core's weight-FIFO pushes, initial-activation writes and `start_mlp`. It then waits for layer completion, captures the two 32-bit accumulator results and returns them as a framed byte response on an output valid/ready stream.

---
 rtl/mlp_host_bridge.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_mlp_host_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_host_bridge.sv
// Byte-stream command front end for the 2x2 MLP core: parses host opcodes, drives
// weight pushes, activation writes and start, then returns a framed result.
module mlp_host_bridge #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [7:0]         out_data,
  input  logic               out_ready,
  output logic               wf_push_col0,
  output logic               wf_push_col1,
  output logic [7:0]         wf_data_in,
  output logic               wf_reset,
  output logic               init_act_valid,
  output logic [15:0]        init_act_data,
  output logic               start_mlp,
  output logic               weights_ready,
  input  logic [3:0]         mlp_state,
  input  logic               layer_complete,
  input  logic signed [31:0] acc0,
  input  logic signed [31:0] acc1,
  output logic               cmd_error
);

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_W_BYTES       = 3'd1,
    ST_A_BYTES       = 3'd2,
    ST_WRESET_P      = 3'd3,
    ST_RUN_WAIT_IDLE = 3'd4,
    ST_RUN_START     = 3'd5,
    ST_RUN_WAIT_DONE = 3'd6,
    ST_RESP          = 3'd7
  } state_t;

  localparam logic [7:0] OP_LOAD_W = 8'h01;
  localparam logic [7:0] OP_LOAD_A = 8'h02;
  localparam logic [7:0] OP_RUN    = 8'h03;
  localparam logic [7:0] OP_WRESET = 8'h04;
  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_TMO    = 8'hEE;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

  // Byte idx of the captured result {acc1, acc0}, little-endian per accumulator.
  function automatic logic [7:0] result_byte(input logic [63:0] res, input logic [2:0] idx);
    result_byte = res[{idx, 3'b000} +: 8];
  endfunction

  state_t          state_r, state_n;
  logic [2:0]      cnt_r, cnt_n, cnt_inc_s;
  logic [TO_W-1:0] to_cnt_r, to_cnt_n;
  logic [7:0]      lo_r, lo_n;
  logic [63:0]     res_r, res_n;
  logic            tmo_r, tmo_n;
  logic            hdr_r, hdr_n;
  logic            in_ready_r, in_ready_n;
  logic            out_valid_r, out_valid_n;
  logic [7:0]      out_data_r, out_data_n;
  logic            push0_r, push0_n, push1_r, push1_n;
  logic [7:0]      wf_data_r, wf_data_n;
  logic            wf_reset_r, wf_reset_n;
  logic            act_valid_r, act_valid_n;
  logic [15:0]     act_data_r, act_data_n;
  logic            start_r, start_n;
  logic            wr_r, wr_n;
  logic            err_r, err_n;
  logic            accept_s;

  assign accept_s  = in_valid && in_ready_r;
  assign cnt_inc_s = cnt_r + 3'd1;

  // Next-state and next-output decode.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    to_cnt_n    = to_cnt_r;
    lo_n        = lo_r;
    res_n       = res_r;
    tmo_n       = tmo_r;
    hdr_n       = hdr_r;
    out_valid_n = out_valid_r;
    out_data_n  = out_data_r;
    push0_n     = 1'b0;
    push1_n     = 1'b0;
    wf_data_n   = wf_data_r;
    wf_reset_n  = 1'b0;
    act_valid_n = 1'b0;
    act_data_n  = act_data_r;
    start_n     = 1'b0;
    wr_n        = wr_r;
    err_n       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          cnt_n = 3'd0;
          case (in_data)
            OP_LOAD_W: state_n = ST_W_BYTES;
            OP_LOAD_A: state_n = ST_A_BYTES;
            OP_RUN:    state_n = ST_RUN_WAIT_IDLE;
            OP_WRESET: begin
              state_n    = ST_WRESET_P;
              wf_reset_n = 1'b1;
              wr_n       = 1'b0;
            end
            default:   err_n = 1'b1;
          endcase
        end else begin
          state_n = ST_IDLE;
        end
      end

      ST_W_BYTES: begin
        if (accept_s) begin
          wf_data_n = in_data;
          // B0/B1 feed column 0, B2/B3 feed column 1.
          if (cnt_r[1] == 1'b0) begin
            push0_n = 1'b1;
          end else begin
            push1_n = 1'b1;
          end
          if (cnt_r == 3'd3) begin
            state_n = ST_IDLE;
            wr_n    = 1'b1;
          end else begin
            cnt_n = cnt_inc_s;
          end
        end else begin
          state_n = ST_W_BYTES;
        end
      end

      ST_A_BYTES: begin
        if (accept_s) begin
          if (cnt_r[0] == 1'b0) begin
            lo_n = in_data;
          end else begin
            act_valid_n = 1'b1;
            act_data_n  = {in_data, lo_r};
          end
          if (cnt_r == 3'd3) begin
            state_n = ST_IDLE;
          end else begin
            cnt_n = cnt_inc_s;
          end
        end else begin
          state_n = ST_A_BYTES;
        end
      end

      ST_WRESET_P: state_n = ST_IDLE;

      ST_RUN_WAIT_IDLE: begin
        if (mlp_state == 4'd0) begin
          state_n = ST_RUN_START;
          start_n = 1'b1;
        end else begin
          state_n = ST_RUN_WAIT_IDLE;
        end
      end

      ST_RUN_START: begin
        state_n  = ST_RUN_WAIT_DONE;
        to_cnt_n = {TO_W{1'b0}};
      end

      ST_RUN_WAIT_DONE: begin
        // Completion is checked first so it wins over a same-cycle expiry.
        if (layer_complete) begin
          res_n       = {acc1, acc0};
          tmo_n       = 1'b0;
          state_n     = ST_RESP;
          out_valid_n = 1'b1;
          out_data_n  = ST_OK;
          hdr_n       = 1'b1;
          cnt_n       = 3'd0;
          wr_n        = 1'b0;
        end else if (to_cnt_r == TO_LAST) begin
          tmo_n       = 1'b1;
          state_n     = ST_RESP;
          out_valid_n = 1'b1;
          out_data_n  = ST_TMO;
          hdr_n       = 1'b1;
          cnt_n       = 3'd0;
          wr_n        = 1'b0;
        end else begin
          to_cnt_n = (to_cnt_r == TO_MAX) ? to_cnt_r : to_cnt_r + TO_W'(1);
        end
      end

      ST_RESP: begin
        if (out_valid_r && out_ready) begin
          if (hdr_r && tmo_r) begin
            state_n     = ST_IDLE;
            out_valid_n = 1'b0;
          end else if (hdr_r) begin
            hdr_n      = 1'b0;
            cnt_n      = 3'd0;
            out_data_n = result_byte(res_r, 3'd0);
          end else if (cnt_r == 3'd7) begin
            state_n     = ST_IDLE;
            out_valid_n = 1'b0;
          end else begin
            cnt_n      = cnt_inc_s;
            out_data_n = result_byte(res_r, cnt_inc_s);
          end
        end else begin
          state_n = ST_RESP;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    in_ready_n = (state_n == ST_IDLE) || (state_n == ST_W_BYTES) || (state_n == ST_A_BYTES);
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 3'd0;
      to_cnt_r    <= {TO_W{1'b0}};
      lo_r        <= 8'h00;
      res_r       <= 64'h0;
      tmo_r       <= 1'b0;
      hdr_r       <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      push0_r     <= 1'b0;
      push1_r     <= 1'b0;
      wf_data_r   <= 8'h00;
      wf_reset_r  <= 1'b0;
      act_valid_r <= 1'b0;
      act_data_r  <= 16'h0000;
      start_r     <= 1'b0;
      wr_r        <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      to_cnt_r    <= to_cnt_n;
      lo_r        <= lo_n;
      res_r       <= res_n;
      tmo_r       <= tmo_n;
      hdr_r       <= hdr_n;
      in_ready_r  <= in_ready_n;
      out_valid_r <= out_valid_n;
      out_data_r  <= out_data_n;
      push0_r     <= push0_n;
      push1_r     <= push1_n;
      wf_data_r   <= wf_data_n;
      wf_reset_r  <= wf_reset_n;
      act_valid_r <= act_valid_n;
      act_data_r  <= act_data_n;
      start_r     <= start_n;
      wr_r        <= wr_n;
      err_r       <= err_n;
    end
  end

  assign in_ready       = in_ready_r;
  assign out_valid      = out_valid_r;
  assign out_data       = out_data_r;
  assign wf_push_col0   = push0_r;
  assign wf_push_col1   = push1_r;
  assign wf_data_in     = wf_data_r;
  assign wf_reset       = wf_reset_r;
  assign init_act_valid = act_valid_r;
  assign init_act_data  = act_data_r;
  assign start_mlp      = start_r;
  assign weights_ready  = wr_r;
  assign cmd_error      = err_r;

endmodule

// File: tb/tb_mlp_host_bridge.sv
// Directed plus randomized bench for mlp_host_bridge against a frame-level model.
module tb_mlp_host_bridge;
  localparam int TMO = 16;

  logic        clk = 1'b0, reset = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0, layer_complete = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic [3:0]  mlp_state = 4'd0;
  logic [31:0] acc0 = 32'h0, acc1 = 32'h0;
  logic        in_ready, out_valid, wf_push_col0, wf_push_col1, wf_reset;
  logic        init_act_valid, start_mlp, weights_ready, cmd_error;
  logic [7:0]  out_data, wf_data_in;
  logic [15:0] init_act_data;

  int n_cmp = 0, n_mis = 0, cyc = 0;
  int n_start = 0, n_err = 0, n_wfr = 0;
  logic [7:0]  q_c0[$], q_c1[$], q_rsp[$];
  logic [15:0] q_act[$];
  int          q_pcyc[$];

  mlp_host_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .wf_push_col0(wf_push_col0), .wf_push_col1(wf_push_col1), .wf_data_in(wf_data_in),
    .wf_reset(wf_reset), .init_act_valid(init_act_valid), .init_act_data(init_act_data),
    .start_mlp(start_mlp), .weights_ready(weights_ready), .mlp_state(mlp_state),
    .layer_complete(layer_complete), .acc0(acc0), .acc1(acc1), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log of strobes, sampled mid-cycle.
  always @(negedge clk) begin
    if (wf_push_col0 === 1'b1) begin q_c0.push_back(wf_data_in); q_pcyc.push_back(cyc); end
    if (wf_push_col1 === 1'b1) begin q_c1.push_back(wf_data_in); q_pcyc.push_back(cyc); end
    if (init_act_valid === 1'b1) q_act.push_back(init_act_data);
    if (start_mlp === 1'b1) n_start <= n_start + 1;
    if (cmd_error === 1'b1) n_err <= n_err + 1;
    if (wf_reset === 1'b1) n_wfr <= n_wfr + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    bit ok, rdy;
    ok = 1'b0;
    if (gap) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin in_data = 8'($urandom); step(); end
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 64; k++) begin
      rdy = in_ready;
      step();
      if (rdy) begin ok = 1'b1; break; end
    end
    chk("send_accept", ok, 1);
  endtask

  task automatic do_reset();
    bit up;
    up = 1'b0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; layer_complete = 1'b0; mlp_state = 4'd0;
    repeat (3) step();
    chk("reset_outputs", {in_ready, out_valid, out_data, wf_push_col0, wf_push_col1, wf_data_in,
        wf_reset, init_act_valid, init_act_data, start_mlp, weights_ready, cmd_error}, 0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (in_ready === 1'b1) begin up = 1'b1; break; end
      step();
    end
    chk("reset_ready", up, 1);
  endtask

  task automatic load_w(input logic [7:0] b0, b1, b2, b3, input bit gap);
    q_c0.delete(); q_c1.delete(); q_pcyc.delete(); q_act.delete();
    send(8'h01, gap); send(b0, gap); send(b1, gap); send(b2, gap); send(b3, gap);
    in_valid = 1'b0;
    chk("lw_back_idle", in_ready, 1);
    step();
    chk("lw_count", {q_c0.size(), q_c1.size()}, {32'd2, 32'd2});
    if (q_c0.size() == 2 && q_c1.size() == 2)
      chk("lw_data", {q_c0[0], q_c0[1], q_c1[0], q_c1[1]}, {b0, b1, b2, b3});
    chk("lw_wready", weights_ready, 1);
    chk("lw_no_act", q_act.size(), 0);
  endtask

  task automatic load_a(input logic [7:0] l0, h0, l1, h1, input bit gap);
    q_c0.delete(); q_c1.delete(); q_act.delete();
    send(8'h02, gap); send(l0, gap); send(h0, gap); send(l1, gap); send(h1, gap);
    in_valid = 1'b0;
    chk("la_back_idle", in_ready, 1);
    step();
    chk("la_count", q_act.size(), 2);
    if (q_act.size() == 2) chk("la_data", {q_act[0], q_act[1]}, {h0, l0, h1, l1});
    chk("la_no_push", q_c0.size() + q_c1.size(), 0);
  endtask

  task automatic collect(input int mode);
    bit stall, done, rdy;
    logic [7:0] held;
    int viol;
    stall = 1'b0; done = 1'b0; held = 8'h00; viol = 0;
    q_rsp.delete();
    for (int k = 0; k < 300; k++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (k % 4 == 0) || (k % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (stall && (out_valid !== 1'b1 || out_data !== held)) viol++;
      if (out_valid !== 1'b1) begin done = 1'b1; break; end
      out_ready = rdy;
      if (rdy) q_rsp.push_back(out_data);
      stall = !rdy;
      held  = out_data;
      step();
    end
    out_ready = 1'b0;
    chk("rsp_done", done, 1);
    chk("rsp_stable", viol, 0);
    chk("rsp_idle_ready", in_ready, 1);
  endtask

  // d = cycles of waiting before layer_complete; d >= TMO means it never comes.
  task automatic run_cmd(input int busy, input int d, input logic [31:0] a0, a1,
                         input int mode, input bit gap);
    logic [7:0] exp_q[$];
    int s0, viol, wait_n;
    bit found;
    s0 = n_start; viol = 0; wait_n = 0; found = 1'b0;
    if (d < TMO) begin
      exp_q.push_back(8'h00);
      for (int k = 0; k < 4; k++) exp_q.push_back(8'((a0 >> (8 * k)) & 32'hFF));
      for (int k = 0; k < 4; k++) exp_q.push_back(8'((a1 >> (8 * k)) & 32'hFF));
    end else begin
      exp_q.push_back(8'hEE);
    end
    acc0 = $urandom; acc1 = $urandom; layer_complete = 1'b0;
    mlp_state = (busy > 0) ? 4'd3 : 4'd0;
    send(8'h03, gap);
    in_valid = 1'b0;
    if (busy == 0) begin
      chk("run_wait_idle", start_mlp, 0);
      step();
    end else begin
      repeat (busy) begin
        if (start_mlp !== 1'b0) viol++;
        step();
      end
      mlp_state = 4'd0;
      chk("start_while_busy", viol, 0);
    end
    for (int k = 0; k < 16; k++) begin
      if (start_mlp === 1'b1) begin found = 1'b1; wait_n = k; break; end
      step();
    end
    chk("start_seen", found, 1);
    chk("start_latency", wait_n, (busy == 0) ? 0 : 1);
    if (d < TMO) begin
      repeat (d + 1) step();
      chk("pre_done_quiet", out_valid, 0);
      layer_complete = 1'b1; acc0 = a0; acc1 = a1;
      step();
      layer_complete = 1'b0; acc0 = $urandom; acc1 = $urandom;
    end else begin
      repeat (TMO) step();
      chk("pre_tmo_quiet", out_valid, 0);
      step();
    end
    chk("rsp_latency", out_valid, 1);
    collect(mode);
    chk("rsp_len", q_rsp.size(), exp_q.size());
    if (q_rsp.size() == exp_q.size())
      foreach (exp_q[i]) chk($sformatf("rsp_byte%0d", i), q_rsp[i], exp_q[i]);
    chk("start_once", n_start - s0, 1);
    chk("run_wready_clr", weights_ready, 0);
  endtask

  initial begin
    int s_err, s_wfr, sel;
    logic [7:0] op;
    do_reset();

    load_w(8'h03, 8'hFD, 8'h7F, 8'h80, 1'b0);
    if (q_pcyc.size() == 4) chk("lw_consecutive", q_pcyc[3] - q_pcyc[0], 3);
    else chk("lw_push_events", q_pcyc.size(), 4);
    load_a(8'h05, 8'hFE, 8'h10, 8'h20, 1'b0);

    run_cmd(5, 3, 32'h0000012C, 32'hFFFFFF9C, 0, 1'b0);
    run_cmd(0, 2, 32'h0000012C, 32'hFFFFFF9C, 1, 1'b0);
    run_cmd(0, 1000, $urandom, $urandom, 0, 1'b0);
    run_cmd(0, TMO - 1, $urandom, $urandom, 0, 1'b0);

    load_w(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    s_err = n_err; s_wfr = n_wfr;
    send(8'h7A, 1'b0);
    chk("err_pulse", cmd_error, 1);
    chk("err_stays_idle", in_ready, 1);
    send(8'h04, 1'b0);
    in_valid = 1'b0;
    chk("wreset_pulse", wf_reset, 1);
    chk("wreset_wready", weights_ready, 0);
    step();
    chk("err_count", n_err - s_err, 1);
    chk("wreset_count", n_wfr - s_wfr, 1);

    load_w(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    q_c0.delete(); q_c1.delete(); q_act.delete();
    send(8'h01, 1'b0); send(8'hA1, 1'b0); send(8'hA2, 1'b0);
    do_reset();
    repeat (3) step();
    chk("abort_pushes", {q_c0.size(), q_c1.size()}, {32'd2, 32'd0});
    chk("abort_wready", weights_ready, 0);
    load_w(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);

    for (int it = 0; it < 24; it++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: load_w(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        1: load_a(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        2: run_cmd($urandom_range(0, 4), $urandom_range(0, 20), $urandom, $urandom,
                   $urandom_range(0, 2), 1'b1);
        default: begin
          op = 8'($urandom_range(5, 256));
          s_err = n_err;
          send(op, 1'b1);
          in_valid = 1'b0;
          step();
          chk("rand_err_count", n_err - s_err, 1);
          chk("rand_err_idle", in_ready, 1);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
